homa_grant_hdr_tx: RTL and testbench
====================================

# homa_grant_hdr_tx

Downstream consumer of the SRPT grant queue's grant FIFO. Pops 95-bit grant entries (first-word-fall-through) and serializes each into a 34-byte Homa GRANT header on a 64-bit AXI-Stream master, network byte order. Output feeds the UDP/IP encapsulation stage, which resolves `peer_id` to an address.

## Interface
Parameters:
- `LOCAL_PORT`, 16'd4000: Homa source port placed in header bytes 0-1.

Ports:
- `ap_clk`  in  1  sole clock; all logic rising-edge.
- `ap_rst`  in  1  reset, asynchronous, active-high.
- `grant_pkt_empty_i`  in  1  grant FIFO empty.
- `grant_pkt_data_i`  in  95  FWFT head entry; valid whenever empty=0.
- `grant_pkt_read_en_o`  out  1  pop strobe; head consumed on the same edge.
- `m_axis_tdata`  out  64  header beat; byte k in bits [8k+7:8k].
- `m_axis_tkeep`  out  8  byte enables.
- `m_axis_tvalid`  out  1  beat valid.
- `m_axis_tlast`  out  1  final beat of header.
- `m_axis_tready`  in  1  downstream accept.
- `grants_sent_o`  out  32  count of completed headers.

## Operation
- Entry layout: `peer_id` [94:81], `rpc_id` [80:67], `priority` [66:64], `grant_offset` [63:32], `msg_len` [31:0]. `msg_len` is not emitted.
- Header bytes, multi-byte fields big-endian:
  - 0-1: `LOCAL_PORT`.
  - 2-3: `{2'b0, peer_id}`.
  - 4-11: 0.
  - 12: doff 8'h80.
  - 13: type 8'h11 (GRANT).
  - 14-19: 0 (checksum unused).
  - 20-27: `{50'b0, rpc_id}`.
  - 28-31: `grant_offset`.
  - 32: `{5'b0, priority}`.
  - 33: resend_all 8'h00.
- Beats: B0 = bytes 0-7 … B3 = bytes 24-31, all with tkeep 8'hFF. B4 = bytes 32-33 in bits [15:0], tkeep 8'h03, tlast=1, unused bits 0.
- FSM states: IDLE, B0, B1, B2, B3, B4.
  - IDLE with !empty: pop and go to B0.
  - Bn -> Bn+1 on tvalid&&tready.
  - B4 handshake with !empty: pop and go to B0 (back-to-back).
  - B4 handshake with empty: go to IDLE.
- `grant_pkt_read_en_o` = !empty && (state==IDLE || (state==B4 && tready)). Combinational. Entry captured into a 95-bit holding register on that edge.
- `grants_sent_o` increments on each B4 handshake. Wraps 2^32-1 -> 0.

## Timing
- Reset (async assert, synchronous release):
  - state=IDLE, holding register=0, grants_sent_o=0.
  - tvalid=0, tlast=0, tkeep=0, tdata=0.
  - read_en=0 while ap_rst high.
- Latency: pop at edge N; B0 valid from the cycle after N. With tready held high, B4 handshakes 4 cycles after B0.
- Throughput: one header per 5 cycles with continuous tready and a non-empty FIFO; no bubble between B4 and the next B0.
- AXIS rules:
  - Once tvalid is high, tvalid, tdata, tkeep and tlast hold until handshake.
  - tvalid does not depend on tready.
  - tvalid is registered (output of state != IDLE).
- Backpressure: tready low stalls any beat indefinitely. No pop occurs during a stall, including in B4.
- FIFO empty mid-packet is irrelevant: the entry is already held.
- Reset mid-packet: the partial header is abandoned, tvalid drops asynchronously, the popped entry is lost, and the counter clears.

## Structure
- Shared package `homa_pkg`:
  - grant-entry field bit ranges and a packed struct for the 95-bit entry.
  - `HOMA_GRANT` = 8'h11, `HOMA_DOFF` = 8'h80, grant header length 34.
  - a `bswap16/32/64` function set.
- No sub-module. A single FSM plus beat mux; the beat mux is a combinational case on state over the holding register.

## Test plan
- Reset: with ap_rst=1, all outputs 0. Deassert with FIFO empty for 10 cycles -> read_en never pulses, tvalid=0.
- Single grant: entry peer_id=14'h3, rpc_id=14'h3333, priority=3'd5, grant_offset=32'h0001_0000, tready=1.
  - 5 beats on consecutive cycles.
  - B0 tdata=64'h0000_0000_0300_A00F.
  - B1 byte4=8'h80, byte5=8'h11.
  - B3 bytes 28-31 = 00 01 00 00.
  - B4 tdata[15:0]=16'h0005, tkeep=8'h03, tlast=1.
  - grants_sent_o=1.
- Back-to-back: 3 entries queued, tready=1 -> 15 consecutive valid beats, read_en pulses exactly 3 times (on cycle of B4 handshake for entries 2-3), grants_sent_o=3.
- Backpressure: tready=0 for 4 cycles during B2 and for 3 cycles during B4 with FIFO non-empty.
  - B2/B4 data stable throughout.
  - No pop until B4 accepted.
  - Total beats still 5 per header.
- Reset mid-packet: ap_rst pulse during B3 -> tvalid low immediately, state IDLE, counter 0. After release with a queued entry, the next header starts cleanly at B0.
- Counter wrap: force grants_sent_o to 32'hFFFF_FFFF, send one grant -> reads 0.

Source files
------------

// File: rtl/homa_pkg.sv
// Shared Homa definitions: grant-entry layout, header constants and byte-swap helpers.
package homa_pkg;

    localparam int unsigned GRANT_ENTRY_W  = 95;
    localparam int unsigned PEER_ID_MSB    = 94;
    localparam int unsigned PEER_ID_LSB    = 81;
    localparam int unsigned RPC_ID_MSB     = 80;
    localparam int unsigned RPC_ID_LSB     = 67;
    localparam int unsigned PRIO_MSB       = 66;
    localparam int unsigned PRIO_LSB       = 64;
    localparam int unsigned OFFSET_MSB     = 63;
    localparam int unsigned OFFSET_LSB     = 32;
    localparam int unsigned MSG_LEN_MSB    = 31;
    localparam int unsigned MSG_LEN_LSB    = 0;

    localparam logic [7:0]  HOMA_GRANT     = 8'h11;
    localparam logic [7:0]  HOMA_DOFF      = 8'h80;
    localparam int unsigned GRANT_HDR_LEN  = 34;

    typedef struct packed {
        logic [13:0] peer_id;
        logic [13:0] rpc_id;
        logic [2:0]  prio;
        logic [31:0] grant_offset;
        logic [31:0] msg_len;
    } grant_entry_t;

    // Turn a big-endian value into AXIS lane order (byte 0 in bits [7:0]).
    function automatic logic [15:0] bswap16(input logic [15:0] v);
        return {v[7:0], v[15:8]};
    endfunction

    function automatic logic [31:0] bswap32(input logic [31:0] v);
        return {bswap16(v[15:0]), bswap16(v[31:16])};
    endfunction

    function automatic logic [63:0] bswap64(input logic [63:0] v);
        return {bswap32(v[31:0]), bswap32(v[63:32])};
    endfunction

endpackage

// File: rtl/homa_grant_hdr_tx.sv
// Pops grant entries from an FWFT FIFO and emits each as a 34-byte Homa GRANT
// header over five beats of a 64-bit AXI-Stream master.
module homa_grant_hdr_tx
    import homa_pkg::*;
#(
    parameter logic [15:0] LOCAL_PORT = 16'd4000
) (
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic        grant_pkt_empty_i,
    input  logic [94:0] grant_pkt_data_i,
    output logic        grant_pkt_read_en_o,
    output logic [63:0] m_axis_tdata,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready,
    output logic [31:0] grants_sent_o
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_B0   = 3'd1;
    localparam logic [2:0] ST_B1   = 3'd2;
    localparam logic [2:0] ST_B2   = 3'd3;
    localparam logic [2:0] ST_B3   = 3'd4;
    localparam logic [2:0] ST_B4   = 3'd5;

    logic [2:0]   state;
    logic [2:0]   state_next;
    grant_entry_t hold;
    logic [31:0]  sent_cnt;
    logic         last_done;
    logic         unused_msg_len;

    assign m_axis_tvalid = (state != ST_IDLE);
    assign last_done     = (state == ST_B4) && m_axis_tready;
    assign grants_sent_o = sent_cnt;
    assign unused_msg_len = ^hold.msg_len;

    // Reset gating keeps the FIFO untouched while the block is held in reset.
    assign grant_pkt_read_en_o = !ap_rst && !grant_pkt_empty_i &&
                                 ((state == ST_IDLE) || last_done);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (!grant_pkt_empty_i) state_next = ST_B0;
            ST_B0:   if (m_axis_tready) state_next = ST_B1;
            ST_B1:   if (m_axis_tready) state_next = ST_B2;
            ST_B2:   if (m_axis_tready) state_next = ST_B3;
            ST_B3:   if (m_axis_tready) state_next = ST_B4;
            ST_B4: begin
                if (m_axis_tready) begin
                    state_next = grant_pkt_empty_i ? ST_IDLE : ST_B0;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state    <= ST_IDLE;
            hold     <= '0;
            sent_cnt <= '0;
        end else begin
            state <= state_next;
            if (grant_pkt_read_en_o) begin
                hold <= grant_entry_t'(grant_pkt_data_i);
            end
            if (last_done) begin
                sent_cnt <= sent_cnt + 32'd1;
            end
        end
    end

    // Beat mux: header fields are laid out big-endian, then swapped into lane order.
    always_comb begin
        m_axis_tdata = '0;
        m_axis_tkeep = '0;
        m_axis_tlast = 1'b0;
        case (state)
            ST_B0: begin
                m_axis_tdata = bswap64({LOCAL_PORT, 2'b00, hold.peer_id, 32'h0});
                m_axis_tkeep = 8'hFF;
            end
            ST_B1: begin
                m_axis_tdata = bswap64({32'h0, HOMA_DOFF, HOMA_GRANT, 16'h0});
                m_axis_tkeep = 8'hFF;
            end
            ST_B2: begin
                // Checksum bytes and the upper half of the 64-bit RPC id: all zero.
                m_axis_tdata = '0;
                m_axis_tkeep = 8'hFF;
            end
            ST_B3: begin
                m_axis_tdata = bswap64({18'h0, hold.rpc_id, hold.grant_offset});
                m_axis_tkeep = 8'hFF;
            end
            ST_B4: begin
                m_axis_tdata = {48'h0, bswap16({5'b0, hold.prio, 8'h00})};
                m_axis_tkeep = 8'h03;
                m_axis_tlast = 1'b1;
            end
            default: begin
                m_axis_tdata = '0;
                m_axis_tkeep = '0;
                m_axis_tlast = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_homa_grant_hdr_tx.sv
// Scoreboard bench for homa_grant_hdr_tx: a byte-level header model feeds an
// expected-beat queue that a negedge monitor drains on every handshake.
module tb_homa_grant_hdr_tx;

    localparam logic [15:0] LPORT = 16'd4000;

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic        empty = 1'b1;
    logic [94:0] data = '0;
    logic        read_en;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tvalid;
    logic        tlast;
    logic        tready = 1'b0;
    logic [31:0] grants;

    homa_grant_hdr_tx #(.LOCAL_PORT(LPORT)) dut (
        .ap_clk              (ap_clk),
        .ap_rst              (ap_rst),
        .grant_pkt_empty_i   (empty),
        .grant_pkt_data_i    (data),
        .grant_pkt_read_en_o (read_en),
        .m_axis_tdata        (tdata),
        .m_axis_tkeep        (tkeep),
        .m_axis_tvalid       (tvalid),
        .m_axis_tlast        (tlast),
        .m_axis_tready       (tready),
        .grants_sent_o       (grants)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    logic [94:0] fifo[$];
    beat_t       expq[$];
    int          checks = 0;
    int          failures = 0;
    int          pops = 0;
    int          beat_idx = 0;
    int          cyc = 0;
    int          hs_count = 0;
    int          hs_first = -1;
    int          hs_last = -1;
    logic [31:0] exp_cnt = '0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_d;
    logic [7:0]  prev_k;
    logic        prev_l;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic refresh();
        empty = (fifo.size() == 0);
        data  = empty ? '0 : fifo[0];
    endtask

    function automatic logic [94:0] mk_entry(input logic [13:0] peer, input logic [13:0] rpc,
                                             input logic [2:0] prio, input logic [31:0] off,
                                             input logic [31:0] len);
        return {peer, rpc, prio, off, len};
    endfunction

    // Reference: build the 34 header bytes, then cut them into 8-byte lanes.
    task automatic push_grant(input logic [94:0] e);
        logic [7:0]  h[40];
        logic [13:0] peer;
        logic [13:0] rpc;
        logic [63:0] rpc64;
        logic [31:0] off;
        beat_t       b;
        peer = e[94:81];
        rpc  = e[80:67];
        off  = e[63:32];
        rpc64 = {50'b0, rpc};
        for (int i = 0; i < 40; i++) h[i] = 8'h00;
        h[0]  = LPORT[15:8];
        h[1]  = LPORT[7:0];
        h[2]  = {2'b00, peer[13:8]};
        h[3]  = peer[7:0];
        h[12] = 8'h80;
        h[13] = 8'h11;
        for (int i = 0; i < 8; i++) h[20+i] = rpc64[63-8*i -: 8];
        for (int i = 0; i < 4; i++) h[28+i] = off[31-8*i -: 8];
        h[32] = {5'b0, e[66:64]};
        h[33] = 8'h00;
        for (int bi = 0; bi < 5; bi++) begin
            b.d = '0;
            b.k = '0;
            for (int k = 0; k < 8; k++) begin
                if (8*bi + k < 34) begin
                    b.d[8*k +: 8] = h[8*bi+k];
                    b.k[k] = 1'b1;
                end
            end
            b.l = (bi == 4);
            expq.push_back(b);
        end
        fifo.push_back(e);
        refresh();
    endtask

    function automatic logic [94:0] rand_entry();
        return mk_entry(14'($urandom), 14'($urandom), 3'($urandom), $urandom, $urandom);
    endfunction

    // FWFT FIFO model: head consumed on the edge where read_en was high.
    always @(posedge ap_clk) begin : fifo_model
        logic p;
        p = read_en;
        #1;
        if (p) begin
            if (fifo.size() > 0) void'(fifo.pop_front());
            pops++;
        end
        refresh();
    end

    always @(negedge ap_clk) begin : monitor
        beat_t e;
        cyc++;
        if (ap_rst) begin
            check("rst_tvalid", tvalid, 0);
            check("rst_tlast", tlast, 0);
            check("rst_tkeep", tkeep, 0);
            check("rst_tdata", tdata, 0);
            check("rst_read_en", read_en, 0);
            check("rst_grants", grants, 0);
            prev_stall = 1'b0;
            beat_idx = 0;
        end else begin
            check("read_en", read_en, !empty && (!tvalid || (tready && tlast)));
            check("grants_sent", grants, exp_cnt);
            if (prev_stall) begin
                check("stall_tvalid", tvalid, 1);
                check("stall_tdata", tdata, prev_d);
                check("stall_tkeep", tkeep, prev_k);
                check("stall_tlast", tlast, prev_l);
            end
            if (tvalid && tready) begin
                if (hs_first < 0) hs_first = cyc;
                hs_last = cyc;
                hs_count++;
                if (expq.size() == 0) begin
                    check("unexpected_beat", tdata, 64'hx);
                end else begin
                    e = expq.pop_front();
                    check("beat_tdata", tdata, e.d);
                    check("beat_tkeep", tkeep, e.k);
                    check("beat_tlast", tlast, e.l);
                end
                beat_idx = tlast ? 0 : beat_idx + 1;
                if (tlast) exp_cnt = exp_cnt + 32'd1;
            end
            prev_stall = tvalid && !tready;
            prev_d = tdata;
            prev_k = tkeep;
            prev_l = tlast;
        end
    end

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((expq.size() != 0 || fifo.size() != 0) && n < 500) begin
            @(posedge ap_clk);
            n++;
        end
        @(negedge ap_clk);
        #1;
        check({name, "_drained"}, expq.size(), 0);
    endtask

    task automatic wait_beat(input int idx, input string name);
        bit found;
        found = 0;
        for (int n = 0; n < 100 && !found; n++) begin
            @(posedge ap_clk);
            #1;
            if (tvalid && beat_idx == idx) found = 1;
        end
        check({name, "_beat_reached"}, found, 1);
    endtask

    task automatic reset_hs();
        hs_count = 0;
        hs_first = -1;
        hs_last = -1;
    endtask

    initial begin
        int p0;
        refresh();
        repeat (3) @(posedge ap_clk);
        #1 ap_rst = 1'b0;

        // Idle with empty FIFO: nothing popped, nothing valid.
        repeat (10) @(posedge ap_clk);
        #1;
        check("idle_pops", pops, 0);
        check("idle_tvalid", tvalid, 0);

        // Single grant, tready high: five beats back to back.
        tready = 1'b1;
        reset_hs();
        push_grant(mk_entry(14'h3, 14'h3333, 3'd5, 32'h0001_0000, 32'h1234));
        drain("single");
        check("single_beats", hs_count, 5);
        check("single_span", hs_last - hs_first, 4);
        check("single_grants", grants, 1);

        // Three queued entries: 15 beats with no bubble, 3 pops.
        p0 = pops;
        reset_hs();
        for (int i = 0; i < 3; i++) push_grant(rand_entry());
        drain("b2b");
        check("b2b_pops", pops - p0, 3);
        check("b2b_beats", hs_count, 15);
        check("b2b_span", hs_last - hs_first, 14);
        check("b2b_grants", grants, 4);

        // Backpressure on B2 and on B4 with another entry waiting.
        reset_hs();
        push_grant(rand_entry());
        push_grant(rand_entry());
        wait_beat(2, "bp_b2");
        tready = 1'b0;
        p0 = pops;
        repeat (4) @(posedge ap_clk);
        #1 tready = 1'b1;
        wait_beat(4, "bp_b4");
        tready = 1'b0;
        repeat (3) @(posedge ap_clk);
        #1;
        check("bp_no_pop_in_b4", pops - p0, 0);
        tready = 1'b1;
        drain("bp");
        check("bp_beats", hs_count, 10);

        // Randomised traffic with random backpressure.
        for (int i = 0; i < 300; i++) begin
            @(posedge ap_clk);
            #1;
            tready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) push_grant(rand_entry());
        end
        tready = 1'b1;
        drain("random");

        // Reset in the middle of B3; header abandoned, counter cleared.
        push_grant(rand_entry());
        wait_beat(3, "mid_rst");
        #2 ap_rst = 1'b1;
        #1;
        check("mid_rst_tvalid", tvalid, 0);
        check("mid_rst_grants", grants, 0);
        expq.delete();
        exp_cnt = '0;
        push_grant(mk_entry(14'h1abc, 14'h0042, 3'd7, 32'hdead_beef, 32'h0));
        repeat (2) @(posedge ap_clk);
        #1 ap_rst = 1'b0;
        reset_hs();
        drain("post_rst");
        check("post_rst_beats", hs_count, 5);
        check("post_rst_grants", grants, 1);

        // Counter wrap.
        @(posedge ap_clk);
        #1 force dut.sent_cnt = 32'hFFFF_FFFF;
        #1 release dut.sent_cnt;
        exp_cnt = 32'hFFFF_FFFF;
        push_grant(rand_entry());
        drain("wrap");
        check("wrap_grants", grants, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
